edge_event_arbiter: RTL

Multi-channel rising-edge event collector and round-robin scheduler. It watches N level inputs, detects each 0->1 transition, and latches it as a pending event per channel. It serialises pending events onto a single valid/ready event port, one channel ID per transfer, with fair rotation between channels. It sits between raw level sources (buttons, status lines, FSM flags) and a single downstream consumer that handles one event at a time.

---
 rtl/edge_event_arbiter_if.sv | 21 ++
 rtl/edge_event_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/edge_event_arbiter_if.sv
// rtl/edge_event_arbiter_if.sv - event handshake bundle for edge_event_arbiter
// Master presents a channel ID with valid; slave accepts it with ready.
interface edge_event_arbiter_if #(
  parameter int IW = 2
);
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_id;

  modport master (
    output evt_valid,
    output evt_id,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    output evt_ready
  );
endinterface

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - rising-edge event collector with round-robin serialiser
// Latches per-channel 0->1 edges and presents them one ID at a time on a valid/ready port.
module edge_event_arbiter #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           level,
  input  logic [N-1:0]           mask,
  edge_event_arbiter_if.master   evt,
  output logic [N-1:0]           pending,
  output logic [CW-1:0]          drop_count
);
  localparam int IW = $clog2(N);
  localparam int SW = CW + 5;
  localparam logic [CW-1:0] DROP_MAX = {CW{1'b1}};

  typedef enum logic {
    S_IDLE,
    S_PRESENT
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] id_q, id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  pending_q, pending_d;
  logic [N-1:0]  prev_q;
  logic [CW-1:0] drop_q, drop_d;

  logic [N-1:0]  rise;
  logic [N-1:0]  grant_vec;
  logic [N-1:0]  drop_vec;
  logic          found;
  logic          grant;
  logic [IW-1:0] winner;
  logic [IW:0]   scan;
  logic [4:0]    drop_cnt;
  logic [SW-1:0] drop_sum;

  always_ff @(posedge clk) begin
    // prev tracks level even in reset so a level high at release is not an edge
    prev_q <= level;
    if (reset) begin
      state_q   <= S_IDLE;
      id_q      <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    rise      = level & ~prev_q & mask;
    found     = 1'b0;
    winner    = '0;
    scan      = '0;
    grant     = 1'b0;
    grant_vec = '0;
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;

    // Scan upward from ptr with wrap at N (N need not be a power of two)
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(N)) scan = scan - (IW+1)'(N);
      if (!found && pending_q[scan[IW-1:0]]) begin
        found  = 1'b1;
        winner = scan[IW-1:0];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (found) grant = 1'b1;
      end
      S_PRESENT: begin
        if (evt.evt_ready) begin
          if (found) grant = 1'b1;
          else       state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (grant) begin
      state_d           = S_PRESENT;
      id_d              = winner;
      ptr_d             = (winner == IW'(N-1)) ? '0 : winner + 1'b1;
      grant_vec[winner] = 1'b1;
    end

    // A rise on the grant edge refills the slot rather than counting as a drop
    drop_vec  = rise & pending_q & ~grant_vec;
    pending_d = (pending_q & ~grant_vec) | rise;
    drop_cnt  = 5'($countones(drop_vec));
    drop_sum  = {5'b0, drop_q} + {{CW{1'b0}}, drop_cnt};
    drop_d    = (drop_sum > {5'b0, DROP_MAX}) ? DROP_MAX : drop_sum[CW-1:0];
  end

  assign evt.evt_valid = (state_q == S_PRESENT);
  assign evt.evt_id    = id_q;
  assign pending       = pending_q;
  assign drop_count    = drop_q;
endmodule
